// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the CONV layer sequencer and datapath.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } conv_state_e;

  function automatic int conv_out_size(input int input_size, input int kernel_size,
                                       input int stride);
    return (input_size - kernel_size) / stride + 1;
  endfunction

  // Address/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// Nested 2-D wrap counter: col steps each enabled cycle, row steps when col wraps.
module conv_win_cnt #(
  parameter int max = 3,
  parameter int w   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [w-1:0] o_row,
  output logic [w-1:0] o_col,
  output logic         o_wrap
);

  localparam logic [w-1:0] LAST = w'(max - 1);

  logic [w-1:0] r_row;
  logic [w-1:0] r_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  // Decodes the final (row, col) position; the caller qualifies it with its enable.
  assign o_wrap = (r_row == LAST) && (r_col == LAST);

endmodule

// File: rtl/conv_sched.sv
// Convolution sequencer: walks every output window, emits per-tap buffer/weight
// addresses and MAC controls, then offers the output index on a valid/ready port.
module conv_sched
  import conv_pkg::*;
#(
  parameter int input_size  = 9,
  parameter int kernel_size = 3,
  parameter int stride      = 1,
  localparam int OUT_SIZE = conv_out_size(input_size, kernel_size, stride),
  localparam int IN_AW    = clog2_min1(input_size * input_size),
  localparam int W_AW     = clog2_min1(kernel_size * kernel_size),
  localparam int OUT_AW   = clog2_min1(OUT_SIZE * OUT_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic [IN_AW-1:0]  o_in_addr,
  output logic [W_AW-1:0]   o_w_addr,
  output logic              o_mac_clr,
  output logic              o_mac_en,
  output logic              o_mac_last,
  output logic [OUT_AW-1:0] o_out_addr,
  output logic              o_valid_conv,
  output logic              o_end_conv
);

  if ((kernel_size > input_size) || (((input_size - kernel_size) % stride) != 0)) begin : g_param_err
    $error("conv_sched: kernel/stride do not tile the input feature map");
  end

  localparam int KW  = clog2_min1(kernel_size);
  localparam int OW  = clog2_min1(OUT_SIZE);
  localparam int PW  = IN_AW + 1;
  localparam int OPW = OUT_AW + 1;

  conv_state_e r_state;
  conv_state_e w_next;

  logic [KW-1:0] w_ky;
  logic [KW-1:0] w_kx;
  logic [OW-1:0] w_oy;
  logic [OW-1:0] w_ox;
  logic          w_k_wrap;
  logic          w_o_wrap;
  logic          w_accept;
  logic [PW-1:0] w_in_row;
  logic [PW-1:0] w_in_full;
  logic [PW-1:0] w_w_full;
  logic [OPW-1:0] w_out_full;

  // Valid/ready: an output is transferred on any cycle where o_valid_conv and
  // i_out_ready are both high; o_valid_conv is a pure decode of state and
  // never waits on i_out_ready.
  assign w_accept = (r_state == WRITE) && i_out_ready;

  conv_win_cnt #(.max(kernel_size), .w(KW)) u_kern_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ACCUM),
    .i_clr  (r_state == IDLE),
    .o_row  (w_ky),
    .o_col  (w_kx),
    .o_wrap (w_k_wrap)
  );

  conv_win_cnt #(.max(OUT_SIZE), .w(OW)) u_out_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_clr  (r_state == IDLE),
    .o_row  (w_oy),
    .o_col  (w_ox),
    .o_wrap (w_o_wrap)
  );

  assign w_in_row   = PW'(w_oy) * PW'(stride) + PW'(w_ky);
  assign w_in_full  = w_in_row * PW'(input_size) + PW'(w_ox) * PW'(stride) + PW'(w_kx);
  assign w_w_full   = PW'(w_ky) * PW'(kernel_size) + PW'(w_kx);
  assign w_out_full = OPW'(w_oy) * OPW'(OUT_SIZE) + OPW'(w_ox);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = ACCUM;
      ACCUM:   if (w_k_wrap) w_next = WRITE;
      WRITE:   if (i_out_ready) w_next = w_o_wrap ? IDLE : ACCUM;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (r_state != IDLE);
    o_in_addr    = '0;
    o_w_addr     = '0;
    o_mac_clr    = 1'b0;
    o_mac_en     = 1'b0;
    o_mac_last   = 1'b0;
    o_out_addr   = '0;
    o_valid_conv = 1'b0;
    o_end_conv   = 1'b0;
    case (r_state)
      ACCUM: begin
        o_mac_en   = 1'b1;
        o_in_addr  = w_in_full[IN_AW-1:0];
        o_w_addr   = w_w_full[W_AW-1:0];
        o_mac_clr  = (w_ky == '0) && (w_kx == '0);
        o_mac_last = w_k_wrap;
        o_out_addr = w_out_full[OUT_AW-1:0];
      end
      WRITE: begin
        o_valid_conv = 1'b1;
        o_out_addr   = w_out_full[OUT_AW-1:0];
        o_end_conv   = i_out_ready && w_o_wrap;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: three instances (9/3/1, 9/3/2, 3/3/1) driven by scenario tasks.
module tb_conv_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: 9/3/1
  logic       a_start, a_ready, a_busy, a_clr, a_en, a_last, a_valid, a_end;
  logic [6:0] a_in_addr;
  logic [3:0] a_w_addr;
  logic [5:0] a_out_addr;

  conv_sched #(.input_size(9), .kernel_size(3), .stride(1)) u_dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_out_ready(a_ready), .o_busy(a_busy),
    .o_in_addr(a_in_addr), .o_w_addr(a_w_addr), .o_mac_clr(a_clr), .o_mac_en(a_en),
    .o_mac_last(a_last), .o_out_addr(a_out_addr), .o_valid_conv(a_valid), .o_end_conv(a_end)
  );

  // Instance B: 9/3/2
  logic       b_start, b_ready, b_busy, b_clr, b_en, b_last, b_valid, b_end;
  logic [6:0] b_in_addr;
  logic [3:0] b_w_addr;
  logic [3:0] b_out_addr;

  conv_sched #(.input_size(9), .kernel_size(3), .stride(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_out_ready(b_ready), .o_busy(b_busy),
    .o_in_addr(b_in_addr), .o_w_addr(b_w_addr), .o_mac_clr(b_clr), .o_mac_en(b_en),
    .o_mac_last(b_last), .o_out_addr(b_out_addr), .o_valid_conv(b_valid), .o_end_conv(b_end)
  );

  // Instance C: 3/3/1
  logic       c_start, c_ready, c_busy, c_clr, c_en, c_last, c_valid, c_end;
  logic [3:0] c_in_addr;
  logic [3:0] c_w_addr;
  logic [0:0] c_out_addr;

  conv_sched #(.input_size(3), .kernel_size(3), .stride(1)) u_dut_c (
    .clk(clk), .rst(rst), .i_start(c_start), .i_out_ready(c_ready), .o_busy(c_busy),
    .o_in_addr(c_in_addr), .o_w_addr(c_w_addr), .o_mac_clr(c_clr), .o_mac_en(c_en),
    .o_mac_last(c_last), .o_out_addr(c_out_addr), .o_valid_conv(c_valid), .o_end_conv(c_end)
  );

  // Scoreboard for A: per-tap {in_addr, w_addr, clr, last} and per-output index.
  logic [12:0] exp_q[$];
  logic [5:0]  exp_out_q[$];
  logic [6:0]  exp_first_q[$];
  int first_win[9] = '{0, 1, 2, 9, 10, 11, 18, 19, 20};

  task automatic load_a();
    exp_q.delete();
    exp_out_q.delete();
    for (int oy = 0; oy < 7; oy++)
      for (int ox = 0; ox < 7; ox++) begin
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            exp_q.push_back({7'((oy + ky) * 9 + ox + kx), 4'(ky * 3 + kx),
                             1'(ky == 0 && kx == 0), 1'(ky == 2 && kx == 2)});
        exp_out_q.push_back(6'(oy * 7 + ox));
      end
  endtask

  task automatic pass_a(input int stall_len, input bit poke, output int busy,
                        output int nout, output int nend);
    int stalled = 0;
    int ntap = 0;
    int cyc = 0;
    logic [12:0] exp_t;
    logic [5:0]  exp_o;
    load_a();
    busy = 0; nout = 0; nend = 0;
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    while (nend == 0 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      a_start = poke && a_en && ($urandom_range(0, 3) == 0);
      a_ready = !(a_valid && nout == 0 && stalled < stall_len);
      if (a_valid && !a_ready) stalled++;
      #1;
      if (a_busy) busy++;
      if (a_en) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL tap_extra: got tap %0d expected none", ntap);
        end else begin
          exp_t = exp_q.pop_front();
          if ({a_in_addr, a_w_addr, a_clr, a_last} !== exp_t) begin
            tests_failed++;
            $display("FAIL tap_%0d: got in=%0d w=%0d clr=%0b last=%0b expected in=%0d w=%0d clr=%0b last=%0b",
                     ntap, a_in_addr, a_w_addr, a_clr, a_last,
                     exp_t[12:6], exp_t[5:2], exp_t[1], exp_t[0]);
          end
        end
        if (ntap < 9) begin
          tests_run++;
          if (a_in_addr !== 7'(first_win[ntap])) begin
            tests_failed++;
            $display("FAIL first_window: got %0d expected %0d", a_in_addr, first_win[ntap]);
          end
        end
        ntap++;
      end
      if (a_valid) begin
        tests_run++;
        if (a_en !== 1'b0 || a_clr !== 1'b0 || a_last !== 1'b0) begin
          tests_failed++;
          $display("FAIL mac_in_write: got en=%0b clr=%0b last=%0b expected 0", a_en, a_clr, a_last);
        end
        if (!a_ready) begin
          tests_run++;
          if (a_out_addr !== 6'd0 || a_end !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold: got addr=%0d end=%0b expected addr=0 end=0", a_out_addr, a_end);
          end
        end else begin
          exp_o = exp_out_q.pop_front();
          nout++;
          tests_run++;
          if (a_out_addr !== exp_o) begin
            tests_failed++;
            $display("FAIL out_addr: got %0d expected %0d", a_out_addr, exp_o);
          end
          tests_run++;
          if (a_end !== (exp_out_q.size() == 0)) begin
            tests_failed++;
            $display("FAIL end_conv: got %0b expected %0b", a_end, exp_out_q.size() == 0);
          end
          if (a_end) nend++;
        end
      end else if (a_end) begin
        tests_run++;
        tests_failed++;
        $display("FAIL end_without_valid: got 1 expected 0");
      end
    end
    a_start = 1'b0;
    tests_run++;
    if (nend == 0) begin
      tests_failed++;
      $display("FAIL pass_timeout: got 0 end pulses expected 1");
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_end: got busy=%0b expected 0", a_busy);
    end
  endtask

  task automatic check_pass(input string name, input int busy, input int nout, input int nend,
                            input int exp_busy);
    tests_run++;
    if (busy != exp_busy || nout != 49 || nend != 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: got busy=%0d outs=%0d ends=%0d left=%0d expected busy=%0d outs=49 ends=1 left=0",
               name, busy, nout, nend, exp_q.size(), exp_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_start = 0; a_ready = 1; b_start = 0; b_ready = 1; c_start = 0; c_ready = 1;
    #1;
    tests_run++;
    if ({a_busy, a_in_addr, a_w_addr, a_clr, a_en, a_last, a_out_addr, a_valid, a_end,
         b_busy, b_in_addr, b_out_addr, b_valid, c_busy, c_in_addr, c_valid, c_end} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got nonzero expected all zero");
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_base();
    int busy, nout, nend;
    pass_a(0, 1'b0, busy, nout, nend);
    check_pass("base_pass", busy, nout, nend, 490);
  endtask

  task automatic test_backpressure();
    int busy, nout, nend;
    pass_a(5, 1'b0, busy, nout, nend);
    check_pass("backpressure", busy, nout, nend, 495);
  endtask

  task automatic test_start_busy();
    int busy, nout, nend;
    pass_a(0, 1'b1, busy, nout, nend);
    check_pass("start_while_busy", busy, nout, nend, 490);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    bit seen = 0;
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    while (!seen && cyc < 1000) begin
      cyc++;
      @(negedge clk); #1;
      if (a_end) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL b2b_first_end: got none expected one");
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_busy !== 1'b0 || a_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got busy=%0b en=%0b expected 0 0", a_busy, a_en);
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_en !== 1'b1 || a_clr !== 1'b1 || a_in_addr !== 7'd0) begin
      tests_failed++;
      $display("FAIL b2b_restart: got en=%0b clr=%0b in=%0d expected 1 1 0", a_en, a_clr, a_in_addr);
    end
    a_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nout = 0;
    int cyc = 0;
    int ends = 0;
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    while (!(nout == 20 && a_en) && cyc < 1000) begin
      cyc++;
      if (a_valid) nout++;
      @(negedge clk); #1;
    end
    tests_run++;
    if (nout != 20 || a_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_reach: got outs=%0d en=%0b expected 20 1", nout, a_en);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({a_busy, a_in_addr, a_w_addr, a_clr, a_en, a_last, a_out_addr, a_valid, a_end} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_async: got busy=%0b in=%0d en=%0b expected all zero", a_busy, a_in_addr, a_en);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (a_end || a_busy) ends++;
    end
    tests_run++;
    if (ends != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", ends);
    end
    a_start = 1'b1;
    @(negedge clk); #1;
    a_start = 1'b0;
    tests_run++;
    if (a_en !== 1'b1 || a_clr !== 1'b1 || a_in_addr !== 7'd0 || a_w_addr !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: got en=%0b clr=%0b in=%0d w=%0d expected 1 1 0 0",
               a_en, a_clr, a_in_addr, a_w_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stride();
    int nout = 0;
    int nwin = -1;
    int cyc = 0;
    int nend = 0;
    logic [6:0] exp_f;
    exp_first_q.delete();
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++)
        exp_first_q.push_back(7'(oy * 2 * 9 + ox * 2));
    @(negedge clk);
    b_start = 1'b1;
    b_ready = 1'b1;
    while (nend == 0 && cyc < 500) begin
      cyc++;
      @(negedge clk);
      b_start = 1'b0;
      #1;
      if (b_en && b_clr) begin
        nwin++;
        exp_f = exp_first_q.pop_front();
        tests_run++;
        if (b_in_addr !== exp_f) begin
          tests_failed++;
          $display("FAIL stride_first_tap_%0d: got %0d expected %0d", nwin, b_in_addr, exp_f);
        end
        if (nwin == 1 || nwin == 4) begin
          tests_run++;
          if (b_in_addr !== ((nwin == 1) ? 7'd2 : 7'd18)) begin
            tests_failed++;
            $display("FAIL stride_out%0d_tap0: got %0d expected %0d", nwin, b_in_addr,
                     (nwin == 1) ? 2 : 18);
          end
        end
      end
      if (b_en && b_last && nwin == 15) begin
        tests_run++;
        if (b_in_addr !== 7'd80) begin
          tests_failed++;
          $display("FAIL stride_last_tap: got %0d expected 80", b_in_addr);
        end
      end
      if (b_valid) begin
        tests_run++;
        if (b_out_addr !== 4'(nout)) begin
          tests_failed++;
          $display("FAIL stride_out_addr: got %0d expected %0d", b_out_addr, nout);
        end
        nout++;
        if (b_end) nend++;
      end
    end
    tests_run++;
    if (nout != 16 || nend != 1 || exp_first_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stride_pass: got outs=%0d ends=%0d expected 16 1", nout, nend);
    end
  endtask

  task automatic test_degenerate();
    int ntap = 0;
    int end_cyc = 0;
    @(negedge clk);
    c_start = 1'b1;
    c_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      c_start = 1'b0;
      #1;
      if (c_en) begin
        tests_run++;
        if (c_in_addr !== 4'(ntap) || c_w_addr !== 4'(ntap) ||
            c_clr !== (ntap == 0) || c_last !== (ntap == 8)) begin
          tests_failed++;
          $display("FAIL degen_tap_%0d: got in=%0d w=%0d clr=%0b last=%0b expected in=%0d w=%0d",
                   ntap, c_in_addr, c_w_addr, c_clr, c_last, ntap, ntap);
        end
        ntap++;
      end
      if (c_end) begin
        end_cyc = cyc;
        tests_run++;
        if (c_out_addr !== 1'b0 || c_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL degen_output: got addr=%0d valid=%0b expected 0 1", c_out_addr, c_valid);
        end
      end
    end
    tests_run++;
    if (ntap != 9 || end_cyc != 10) begin
      tests_failed++;
      $display("FAIL degen_timing: got taps=%0d end_cycle=%0d expected 9 10", ntap, end_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_stride();
    test_degenerate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
